// File: rtl/filter_ctrl_pkg.sv
// Shared definitions for the filter sequencers.
// Contents:
//   tune_state_t : tuning controller states (IDLE, ARMED, DONE)
//   LFSR_TAPS    : Galois LFSR feedback taps (x^32 + x^22 + x^2 + x + 1),
//                  used by the optional idle dither
package filter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } tune_state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/filter_tune_slew.sv
// Combinational slew calculator: moves cur toward target by at most step.
// Ports:
//   cur       in  current tuning word
//   target    in  destination tuning word
//   step      in  maximum change per commit; 0 jumps straight to target
//   next      out value to commit on the next trigger
//   at_target out next equals target
// The move is clamped to the remaining distance, so it never overshoots
// and never wraps.
module filter_tune_slew #(
  parameter int TUNE_WIDTH = 32
) (
  input  logic [TUNE_WIDTH-1:0] cur,
  input  logic [TUNE_WIDTH-1:0] target,
  input  logic [TUNE_WIDTH-1:0] step,
  output logic [TUNE_WIDTH-1:0] next,
  output logic                  at_target
);

  logic [TUNE_WIDTH-1:0] dist_s;
  logic                  jump_s;

  // Clamped step toward target in either direction.
  always_comb begin
    dist_s = {TUNE_WIDTH{1'b0}};
    next   = cur;
    if (target > cur) begin
      dist_s = target - cur;
    end else begin
      dist_s = cur - target;
    end
    jump_s = (step == {TUNE_WIDTH{1'b0}}) || (step >= dist_s);
    if (jump_s) begin
      next = target;
    end else if (target > cur) begin
      next = cur + step;
    end else begin
      next = cur - step;
    end
    at_target = (next == target);
  end

endmodule

// File: rtl/filter_tune_ctrl.sv
// Tuning-word sequencer for the variable digital filter's DDS.
// Accepts a target over valid/ready, then slews the live tuning word toward
// it, committing only on S&H trigger pulses so the phase accumulator never
// sees a mid-period retune. A watchdog forces the final value if triggers
// stall.
// Ports:
//   clk, RST    clock; asynchronous active-high reset
//   tgt_word    requested target word      tgt_step  max change per commit
//   tgt_valid   request valid              tgt_ready request accepted when high
//   sah_trig    one-cycle trigger pulse    abort     cancel ramp (ARMED only)
//   tuning_word live word to DDS           busy      ramp in progress
//   done        one-cycle target-reached   wdog_err  sticky forced-commit flag
// Optional build macro FILTER_TUNE_CTRL_DITHER_EN: LSB dither of the word
// from an LFSR on every trigger while IDLE.
module filter_tune_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int                    TUNE_WIDTH  = 32,
  parameter logic [TUNE_WIDTH-1:0] RESET_WORD  = '0,
  parameter int                    WDOG_CYCLES = 65536,
  parameter int                    WDOG_WIDTH  = $clog2(WDOG_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [TUNE_WIDTH-1:0] tgt_word,
  input  logic [TUNE_WIDTH-1:0] tgt_step,
  input  logic                  tgt_valid,
  output logic                  tgt_ready,
  input  logic                  sah_trig,
  input  logic                  abort,
  output logic [TUNE_WIDTH-1:0] tuning_word,
  output logic                  busy,
  output logic                  done,
  output logic                  wdog_err
);

  localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = WDOG_WIDTH'(WDOG_CYCLES - 1);

  tune_state_t           state_r, state_nxt_s;
  logic [TUNE_WIDTH-1:0] word_r, word_nxt_s;
  logic [TUNE_WIDTH-1:0] tgt_r, step_r;
  logic [WDOG_WIDTH-1:0] wdog_cnt_r, wdog_cnt_nxt_s;
  logic                  wdog_err_r, wdog_err_nxt_s;
  logic                  accept_s;
  logic                  ready_r, busy_r, done_r;
  logic [TUNE_WIDTH-1:0] slew_next_s;
  logic                  slew_at_tgt_s;

  filter_tune_slew #(.TUNE_WIDTH(TUNE_WIDTH)) u_slew (
    .cur       (word_r),
    .target    (tgt_r),
    .step      (step_r),
    .next      (slew_next_s),
    .at_target (slew_at_tgt_s)
  );

`ifdef FILTER_TUNE_CTRL_DITHER_EN
  logic [TUNE_WIDTH-1:0] lfsr_r;
  // Undithered LSB, restored when a new target is accepted.
  logic                  base_lsb_r;

  // Free-running LFSR, advanced once per trigger.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      lfsr_r <= TUNE_WIDTH'(1);
    end else if (sah_trig) begin
      lfsr_r <= lfsr_r[0] ? ((lfsr_r >> 1) ^ TUNE_WIDTH'(LFSR_TAPS)) : (lfsr_r >> 1);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Track the true LSB whenever the word is not being dithered.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      base_lsb_r <= RESET_WORD[0];
    end else if (state_r != IDLE) begin
      base_lsb_r <= word_nxt_s[0];
    end else begin
      base_lsb_r <= base_lsb_r;
    end
  end
`endif

  // Next-state, commit and watchdog decisions.
  always_comb begin
    state_nxt_s    = state_r;
    word_nxt_s     = word_r;
    wdog_cnt_nxt_s = wdog_cnt_r;
    wdog_err_nxt_s = wdog_err_r;
    accept_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (tgt_valid) begin
          accept_s       = 1'b1;
          wdog_cnt_nxt_s = {WDOG_WIDTH{1'b0}};
          wdog_err_nxt_s = 1'b0;
          state_nxt_s    = ARMED;
`ifdef FILTER_TUNE_CTRL_DITHER_EN
          word_nxt_s     = {word_r[TUNE_WIDTH-1:1], base_lsb_r};
`endif
        end else begin
`ifdef FILTER_TUNE_CTRL_DITHER_EN
          if (sah_trig) begin
            word_nxt_s = {word_r[TUNE_WIDTH-1:1], tgt_r[0] ^ lfsr_r[0]};
          end else begin
            word_nxt_s = word_r;
          end
`else
          word_nxt_s = word_r;
`endif
        end
      end
      ARMED: begin
        // Priority: abort, then trigger, then watchdog expiry.
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (sah_trig) begin
          word_nxt_s     = slew_next_s;
          wdog_cnt_nxt_s = {WDOG_WIDTH{1'b0}};
          state_nxt_s    = slew_at_tgt_s ? DONE : ARMED;
        end else if (wdog_cnt_r == WDOG_LAST) begin
          word_nxt_s     = tgt_r;
          wdog_err_nxt_s = 1'b1;
          state_nxt_s    = DONE;
        end else begin
          wdog_cnt_nxt_s = wdog_cnt_r + WDOG_WIDTH'(1);
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r    <= IDLE;
      word_r     <= RESET_WORD;
      tgt_r      <= {TUNE_WIDTH{1'b0}};
      step_r     <= {TUNE_WIDTH{1'b0}};
      wdog_cnt_r <= {WDOG_WIDTH{1'b0}};
      wdog_err_r <= 1'b0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      word_r     <= word_nxt_s;
      wdog_cnt_r <= wdog_cnt_nxt_s;
      wdog_err_r <= wdog_err_nxt_s;
      ready_r    <= (state_nxt_s == IDLE);
      busy_r     <= (state_nxt_s == ARMED);
      done_r     <= (state_nxt_s == DONE);
      if (accept_s) begin
        tgt_r  <= tgt_word;
        step_r <= tgt_step;
      end else begin
        tgt_r  <= tgt_r;
        step_r <= step_r;
      end
    end
  end

  assign tuning_word = word_r;
  assign tgt_ready   = ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign wdog_err    = wdog_err_r;

endmodule

// File: tb/tb_filter_tune_ctrl.sv
// Self-checking bench for filter_tune_ctrl (dither macro undefined).
// A behavioural model tracks the expected outputs every cycle; a vector
// table and hand-written sequences cover the scenarios of interest, followed
// by randomized traffic.
module tb_filter_tune_ctrl;

  localparam int TW = 32;
  localparam int WD = 16;

  logic          clk = 1'b0;
  logic          RST;
  logic [TW-1:0] tgt_word, tgt_step;
  logic          tgt_valid, sah_trig, abort;
  logic          tgt_ready, busy, done, wdog_err;
  logic [TW-1:0] tuning_word;

  filter_tune_ctrl #(
    .TUNE_WIDTH (TW),
    .RESET_WORD (32'd0),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .tgt_word   (tgt_word),
    .tgt_step   (tgt_step),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .sah_trig   (sah_trig),
    .abort      (abort),
    .tuning_word(tuning_word),
    .busy       (busy),
    .done       (done),
    .wdog_err   (wdog_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [TW-1:0] m_word, m_tgt, m_step;
  bit            m_ramp, m_done, m_err;
  int            m_cnt;

  typedef struct {
    logic          v;
    logic [TW-1:0] w;
    logic [TW-1:0] s;
    logic          t;
    logic          a;
    logic [TW-1:0] e_word;
    logic          e_busy;
    logic          e_done;
    logic          e_ready;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_word = 32'd0; m_tgt = 32'd0; m_step = 32'd0;
    m_ramp = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  // One clock of the specified behaviour, using the inputs present at the edge.
  task automatic model_step();
    longint d, mag, mv;
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_ramp) begin
      if (tgt_valid) begin
        m_tgt = tgt_word; m_step = tgt_step;
        m_cnt = 0; m_err = 1'b0; m_ramp = 1'b1;
      end
    end else if (abort) begin
      m_ramp = 1'b0;
    end else if (sah_trig) begin
      d   = longint'(m_tgt) - longint'(m_word);
      mag = (d < 0) ? -d : d;
      mv  = (m_step == 32'd0 || longint'(m_step) > mag) ? mag : longint'(m_step);
      m_word = 32'(longint'(m_word) + ((d < 0) ? -mv : mv));
      m_cnt  = 0;
      if (m_word == m_tgt) begin
        m_ramp = 1'b0; m_done = 1'b1;
      end
    end else if (m_cnt == WD - 1) begin
      m_word = m_tgt; m_err = 1'b1; m_ramp = 1'b0; m_done = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".word"},  tuning_word,        m_word);
    chk({tag, ".busy"},  32'(busy),          32'(m_ramp));
    chk({tag, ".done"},  32'(done),          32'(m_done));
    chk({tag, ".ready"}, 32'(tgt_ready),     32'(!m_ramp && !m_done));
    chk({tag, ".wdog"},  32'(wdog_err),      32'(m_err));
  endtask

  task automatic cyc(input logic v, input logic [TW-1:0] w, input logic [TW-1:0] s,
                     input logic t, input logic a, input string tag);
    @(negedge clk);
    tgt_valid = v; tgt_word = w; tgt_step = s; sah_trig = t; abort = a;
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  initial begin
    RST = 1'b1; tgt_valid = 1'b0; tgt_word = 32'd0; tgt_step = 32'd0;
    sah_trig = 1'b0; abort = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    RST = 1'b0;

    // 0 -> 100 step 30, trigger every 8 cycles
    cyc(1'b1, 32'd100, 32'd30, 1'b0, 1'b0, "ramp_acc");
    for (int k = 0; k < 4; k++) begin
      repeat (7) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "ramp_wait");
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "ramp_trig");
      chk("ramp_value", tuning_word, (k == 3) ? 32'd100 : 32'(30 * (k + 1)));
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "ramp_idle");

    // Vector table: jump 100->10, then jump back to 0
    tbl[0] = '{1'b1, 32'd10, 32'd0, 1'b0, 1'b0, 32'd100, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 32'd100, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'd0,  32'd0, 1'b1, 1'b0, 32'd10,  1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 32'd10,  1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'd0,  32'd0, 1'b0, 1'b0, 32'd10,  1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'd0,  32'd0, 1'b1, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 32'd0,   1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].v, tbl[i].w, tbl[i].s, tbl[i].t, tbl[i].a, "tbl_model");
      chk("tbl.word",  tuning_word,    tbl[i].e_word);
      chk("tbl.busy",  32'(busy),      32'(tbl[i].e_busy));
      chk("tbl.done",  32'(done),      32'(tbl[i].e_done));
      chk("tbl.ready", 32'(tgt_ready), 32'(tbl[i].e_ready));
    end

    // Abort together with the third trigger of 0 -> 1000 step 100
    cyc(1'b1, 32'd1000, 32'd100, 1'b0, 1'b0, "abort_acc");
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "abort_wait");
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "abort_trig");
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, "abort_hit");
    chk("abort_word",  tuning_word,    32'd200);
    chk("abort_ready", 32'(tgt_ready), 32'd1);
    chk("abort_done",  32'(done),      32'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, "abort_idle");

    // Watchdog: no trigger for WD armed cycles
    cyc(1'b1, 32'd500, 32'd0, 1'b0, 1'b0, "wdog_acc");
    repeat (WD) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "wdog_wait");
    chk("wdog_word", tuning_word,   32'd500);
    chk("wdog_err",  32'(wdog_err), 32'd1);
    chk("wdog_done", 32'(done),     32'd1);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "wdog_idle");
    cyc(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, "wdog_clr");
    chk("wdog_cleared", 32'(wdog_err), 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "wdog_fin");
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "wdog_fin");

    // Asynchronous reset mid-ramp at word 300
    cyc(1'b1, 32'd1000, 32'd100, 1'b0, 1'b0, "rst_acc");
    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "rst_ramp");
    chk("rst_pre_word", tuning_word, 32'd300);
    #2 RST = 1'b1;
    #1 model_reset();
    check_model("rst_async");
    @(negedge clk);
    RST = 1'b0;
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "rst_after");

    // Top-of-range ramp without wrap, then idle triggers
    cyc(1'b1, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, "top_acc0");
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "top_jump");
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "top_idle0");
    cyc(1'b1, 32'hFFFF_FFFF, 32'h80, 1'b0, 1'b0, "top_acc1");
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "top_t1");
    chk("top_step1", tuning_word, 32'hFFFF_FF80);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "top_t2");
    chk("top_step2", tuning_word, 32'hFFFF_FFFF);
    chk("top_done",  32'(done),   32'd1);
    repeat (4) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "idle_trig");
    chk("idle_static", tuning_word, 32'hFFFF_FFFF);

    // Randomized traffic: frequent triggers, then sparse ones for the watchdog
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 300; i++) begin
        logic          rv, rt, ra;
        logic [TW-1:0] rw, rs;
        rv = ($urandom_range(0, 3) == 0);
        rw = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2000));
        rs = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 600));
        rt = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
        ra = ($urandom_range(0, 29) == 0);
        cyc(rv, rw, rs, rt, ra, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
